tx_frame_controller: RTL and testbench
======================================

Name: tx_frame_controller

Overview:
- Sequences the 802.11 Transmitter datapath for one PPDU at a time.
- Collects one PSDU of LENGTH_BYTES bytes from an upstream byte source through a valid/ready handshake, then issues the single-cycle Start pulse.
- Presents PSDU bits on the Transmitter's serial Input in the exact cycles the Transmitter's PSDU state samples them.
- Holds off the next frame until the encoder/interleaver tail has drained, and provides abort, done and frame-count status.

Parameters:
- LENGTH_BYTES, 16: PSDU length in bytes; must equal the Transmitter's LENGTH field.
- PSDU_OFFSET, 136: cycles from the TxStart cycle to the cycle before the first PSDU bit (96 preamble + 24 SIGNAL + 16 SERVICE).
- POST_PSDU_CYCLES, 96: drain cycles after the last PSDU bit (covers tail, pad bits and WAIT4INTER).
- CNT_W, 16: width of FrameCount.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InData  in  8  PSDU byte from upstream.
- InValid  in  1  InData valid.
- InReady  out  1  controller accepts a byte this cycle.
- Abort  in  1  synchronous abort request.
- TxStart  out  1  to the Transmitter Start input.
- TxInput  out  1  to the Transmitter Input (serial PSDU bit).
- TxReset  out  1  to the Transmitter Reset input; one-cycle pulse on abort.
- Busy  out  1  frame launched and not yet drained.
- FrameDone  out  1  one-cycle pulse when a frame completes.
- FrameCount  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high.
- Values while Reset is high: state IDLE, byte count 0, bit/cycle counters 0, buffer contents don't-care. All outputs are 0: InReady, TxStart, TxInput, TxReset, Busy, FrameDone, FrameCount.
- States: IDLE, FILL, LAUNCH, HEADER, PSDU, DRAIN, DONE.
- IDLE: moves to FILL on the first clock after Reset deasserts.
- FILL:
  - InReady = 1 while byte count < LENGTH_BYTES.
  - A byte is accepted on a rising edge when InValid && InReady. It is written to buffer[count], and count increments.
  - When count reaches LENGTH_BYTES, InReady drops in the same cycle (combinational on count), and the state moves to LAUNCH on the next edge.
  - InValid with InReady = 0 is ignored; no byte is stored.
- Cycle numbering for a frame: the LAUNCH cycle is cycle 0.
- LAUNCH: TxStart = 1 for exactly cycle 0. Busy = 1 from cycle 0 through the end of DRAIN. Next state HEADER.
- HEADER: cycles 1..PSDU_OFFSET. TxInput = 0.
- PSDU:
  - Cycles PSDU_OFFSET+1+k for k = 0..8*LENGTH_BYTES-1.
  - TxInput = bit (k mod 8) of buffer[k div 8], LSB first, driven from a register and stable for the whole cycle.
  - Bit counter width is ceil(log2(8*LENGTH_BYTES))+1. The counter saturates at its terminal value; it does not wrap.
- DRAIN: POST_PSDU_CYCLES cycles with TxInput = 0.
- DONE (one cycle):
  - FrameDone = 1, FrameCount increments, Busy = 0, count clears.
  - Next state FILL; InReady returns to 1 in the cycle after DONE.
- Abort (highest priority; any state except IDLE):
  - On the edge sampling Abort = 1: TxReset = 1 for the following cycle only.
  - TxStart, TxInput and Busy become 0, count clears, and the state goes to FILL.
  - No FrameDone pulse; FrameCount is unchanged.
  - If InValid && InReady coincide with Abort, the byte is discarded.
  - If Abort is held high, TxReset pulses once per assertion edge (rising-edge detect on Abort).
- Abort during LAUNCH: TxStart still asserted in that cycle, followed by TxReset.
- Reset mid-frame: immediate return to reset values. TxReset is not pulsed; the Transmitter shares system reset.
- Upstream stalls are only possible during FILL. Once LAUNCH is entered, the frame runs to completion without further handshakes.

Test Plan:
- Reset then fill: push 16 bytes 0x00..0x0F with InValid held high → InReady high for exactly 16 accepting edges, TxStart pulses 1 cycle, Busy = 1.
- Bit timing: bytes 0x01, then 0x00 ×15 → TxInput = 1 only in cycle 137 (k = 0), 0 in cycles 138..264 and throughout HEADER/DRAIN. FrameDone at cycle 361; FrameCount = 1.
- LSB ordering: byte0 = 0x80 → TxInput = 1 in cycle 144 only within the first byte.
- Back-to-back: two full frames fed without gaps → the second TxStart occurs no earlier than the cycle after the first FrameDone plus 16 fill cycles; FrameCount = 2.
- Abort in PSDU at cycle 200 → TxReset = 1 in cycle 201 only, TxInput = 0 and Busy = 0 from cycle 201, no FrameDone, FrameCount unchanged, InReady = 1 by cycle 202.
- Partial fill plus abort: 5 bytes accepted, Abort with simultaneous InValid → count = 0, that byte not stored. A subsequent 16-byte fill launches normally with the new data only.

Source files
------------

// File: rtl/tx_frame_controller.sv
// Frame sequencer for the 802.11 transmitter. It buffers one PSDU from a valid/ready source,
// launches the transmitter, and serialises the bytes LSB first into the PSDU sampling window.
module tx_frame_controller #(
    parameter int LENGTH_BYTES     = 16,
    parameter int PSDU_OFFSET      = 136,
    parameter int POST_PSDU_CYCLES = 96,
    parameter int CNT_W            = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       inData_i,
    input  logic             inValid_i,
    output logic             inReady_o,
    input  logic             abort_i,
    output logic             txStart_o,
    output logic             txInput_o,
    output logic             txReset_o,
    output logic             busy_o,
    output logic             frameDone_o,
    output logic [CNT_W-1:0] frameCount_o
);

    localparam int CW   = $clog2(LENGTH_BYTES + 1);
    localparam int AW   = $clog2(LENGTH_BYTES);
    localparam int BW   = $clog2(8 * LENGTH_BYTES) + 1;
    localparam int TMAX = (PSDU_OFFSET > POST_PSDU_CYCLES) ? PSDU_OFFSET : POST_PSDU_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LEN_C      = CW'(LENGTH_BYTES);
    localparam logic [BW-1:0] BIT_LAST_C = BW'(8 * LENGTH_BYTES - 1);
    localparam logic [TW-1:0] OFF_C      = TW'(PSDU_OFFSET);
    localparam logic [TW-1:0] POST_C     = TW'(POST_PSDU_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_HEADER = 3'd3;
    localparam logic [2:0] S_PSDU   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BW-1:0]    bitIdx_q, bitIdx_d;
    logic             txInput_q, txInput_d;
    logic             txReset_q, txReset_d;
    logic [CNT_W-1:0] frameCount_q, frameCount_d;
    logic             abortPrev_q;
    logic [7:0]       buffer_q [LENGTH_BYTES];

    logic             abortEdge;
    logic             accept;
    logic [BW-2:0]    nextBit;
    logic             nextBitVal;

    // Abort acts once per assertion; holding it high does not retrigger.
    assign abortEdge  = abort_i && !abortPrev_q && (state_q != S_IDLE);
    assign inReady_o  = (state_q == S_FILL) && (count_q < LEN_C);
    assign accept     = inValid_i && inReady_o && !abortEdge;
    assign nextBit    = bitIdx_q[BW-2:0] + (BW-1)'(1);
    assign nextBitVal = buffer_q[nextBit[BW-2:3]][nextBit[2:0]];

    assign txStart_o    = (state_q == S_LAUNCH);
    assign busy_o       = (state_q == S_LAUNCH) || (state_q == S_HEADER) ||
                          (state_q == S_PSDU)   || (state_q == S_DRAIN);
    assign frameDone_o  = (state_q == S_DONE);
    assign txInput_o    = txInput_q;
    assign txReset_o    = txReset_q;
    assign frameCount_o = frameCount_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timer_d      = timer_q;
        bitIdx_d     = bitIdx_q;
        txInput_d    = txInput_q;
        txReset_d    = 1'b0;
        frameCount_d = frameCount_q;
        case (state_q)
            S_IDLE: state_d = S_FILL;
            S_FILL: begin
                if (accept) count_d = count_q + CW'(1);
                if (count_q == LEN_C) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_HEADER;
                timer_d = TW'(1);
            end
            // The serial bit is registered one cycle ahead so it is stable when sampled.
            S_HEADER: begin
                if (timer_q == OFF_C) begin
                    state_d   = S_PSDU;
                    bitIdx_d  = '0;
                    txInput_d = buffer_q[0][0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_PSDU: begin
                if (bitIdx_q == BIT_LAST_C) begin
                    state_d   = S_DRAIN;
                    txInput_d = 1'b0;
                    timer_d   = TW'(1);
                end else begin
                    bitIdx_d  = {1'b0, nextBit};
                    txInput_d = nextBitVal;
                end
            end
            S_DRAIN: begin
                if (timer_q == POST_C) begin
                    state_d      = S_DONE;
                    frameCount_d = frameCount_q + CNT_W'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_FILL;
                count_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (abortEdge) begin
            state_d      = S_FILL;
            count_d      = '0;
            txInput_d    = 1'b0;
            txReset_d    = 1'b1;
            frameCount_d = frameCount_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            timer_q      <= '0;
            bitIdx_q     <= '0;
            txInput_q    <= 1'b0;
            txReset_q    <= 1'b0;
            frameCount_q <= '0;
            abortPrev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            bitIdx_q     <= bitIdx_d;
            txInput_q    <= txInput_d;
            txReset_q    <= txReset_d;
            frameCount_q <= frameCount_d;
            abortPrev_q  <= abort_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) buffer_q[count_q[AW-1:0]] <= inData_i;
    end

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed bench for tx_frame_controller: fill, bit timing, LSB ordering, back-to-back
// frames, abort in PSDU, abort during a partial fill, and reset mid-frame.
module tb_tx_frame_controller;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  inData_i;
    logic        inValid_i;
    logic        inReady_o;
    logic        abort_i;
    logic        txStart_o;
    logic        txInput_o;
    logic        txReset_o;
    logic        busy_o;
    logic        frameDone_o;
    logic [15:0] frameCount_o;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;
    int doneCycle   = 0;
    int launchCycle = 0;
    int accepts;
    logic [7:0] frameBytes [16];

    tx_frame_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inData_i     (inData_i),
        .inValid_i    (inValid_i),
        .inReady_o    (inReady_o),
        .abort_i      (abort_i),
        .txStart_o    (txStart_o),
        .txInput_o    (txInput_o),
        .txReset_o    (txReset_o),
        .busy_o       (busy_o),
        .frameDone_o  (frameDone_o),
        .frameCount_o (frameCount_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 ns after the edge for driving and sampling.
    task automatic stepCycle();
        @(posedge clk_i);
        #1;
        cycleNum++;
    endtask

    // Feed frameBytes with InValid held high, then wait for the launch cycle (cycle 0).
    task automatic applyStimulus(output int acc);
        logic found;
        acc       = 0;
        found     = 1'b0;
        inValid_i = 1'b1;
        inData_i  = frameBytes[0];
        for (int i = 0; i < 40; i++) begin
            if (!inReady_o) break;
            stepCycle();
            acc++;
            if (acc < 16) inData_i = frameBytes[acc];
        end
        inValid_i = 1'b0;
        checkOutput("accepting edges", acc, 16);
        checkOutput("txStart before launch", txStart_o, 0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            if (txStart_o) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("launch seen", found, 1);
        launchCycle = cycleNum;
        checkOutput("busy at launch", busy_o, 1);
        checkOutput("inReady at launch", inReady_o, 0);
    endtask

    // Walk cycles 1..361 of a frame; PSDU bit k appears in cycle 137+k, FrameDone in 361.
    task automatic runFrame(input int expCount);
        int   k;
        logic expBit;
        for (int c = 1; c <= 361; c++) begin
            stepCycle();
            expBit = 1'b0;
            if (c >= 137 && c <= 264) begin
                k      = c - 137;
                expBit = frameBytes[k / 8][k % 8];
            end
            checkOutput($sformatf("txInput c%0d", c), txInput_o, expBit);
            checkOutput($sformatf("busy c%0d", c), busy_o, c <= 360);
            checkOutput($sformatf("frameDone c%0d", c), frameDone_o, c == 361);
            checkOutput($sformatf("txStart c%0d", c), txStart_o, 0);
        end
        doneCycle = cycleNum;
        stepCycle();
        checkOutput("frameCount after done", frameCount_o, expCount);
        checkOutput("inReady after done", inReady_o, 1);
        checkOutput("frameDone cleared", frameDone_o, 0);
    endtask

    initial begin
        rst_i     = 1'b1;
        inValid_i = 1'b0;
        inData_i  = 8'h00;
        abort_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset inReady", inReady_o, 0);
        checkOutput("reset txStart", txStart_o, 0);
        checkOutput("reset txInput", txInput_o, 0);
        checkOutput("reset txReset", txReset_o, 0);
        checkOutput("reset busy", busy_o, 0);
        checkOutput("reset frameDone", frameDone_o, 0);
        checkOutput("reset frameCount", frameCount_o, 0);
        rst_i = 1'b0;
        stepCycle();
        checkOutput("inReady in first fill", inReady_o, 1);

        // Frame A: counting bytes.
        for (int i = 0; i < 16; i++) frameBytes[i] = 8'(i);
        applyStimulus(accepts);
        runFrame(1);

        // Frame B, back-to-back: only bit 0 of byte 0 is set.
        frameBytes[0] = 8'h01;
        for (int i = 1; i < 16; i++) frameBytes[i] = 8'h00;
        applyStimulus(accepts);
        checkOutput("done to next launch", launchCycle - doneCycle, 18);
        runFrame(2);

        // Frame C: MSB of byte 0 must appear 7 cycles after the first PSDU bit.
        frameBytes = '{8'h80, 8'h3C, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h01, 8'h7E,
                       8'hC3, 8'h10, 8'h08, 8'h99, 8'h66, 8'hF0, 8'h0F, 8'h81};
        applyStimulus(accepts);
        runFrame(3);

        // Frame D: abort sampled at the end of cycle 200, held for a few cycles.
        for (int i = 0; i < 16; i++) frameBytes[i] = 8'hFF;
        applyStimulus(accepts);
        repeat (200) stepCycle();
        checkOutput("txInput before abort", txInput_o, 1);
        checkOutput("busy before abort", busy_o, 1);
        abort_i = 1'b1;
        stepCycle();
        checkOutput("txReset c201", txReset_o, 1);
        checkOutput("txInput c201", txInput_o, 0);
        checkOutput("busy c201", busy_o, 0);
        checkOutput("frameDone c201", frameDone_o, 0);
        stepCycle();
        checkOutput("txReset c202", txReset_o, 0);
        checkOutput("inReady c202", inReady_o, 1);
        stepCycle();
        checkOutput("txReset held abort", txReset_o, 0);
        abort_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("frameDone after abort", frameDone_o, 0);
        end
        checkOutput("frameCount after abort", frameCount_o, 3);

        // Frame E: five bytes, then abort with a coincident byte that must be dropped.
        inValid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inData_i = 8'h11 + 8'(i);
            stepCycle();
        end
        inData_i = 8'h99;
        abort_i  = 1'b1;
        stepCycle();
        abort_i   = 1'b0;
        inValid_i = 1'b0;
        checkOutput("txReset partial abort", txReset_o, 1);
        checkOutput("inReady partial abort", inReady_o, 1);
        for (int i = 0; i < 16; i++) frameBytes[i] = 8'h20 + 8'(i);
        applyStimulus(accepts);
        runFrame(4);

        // Reset in the middle of a header: everything returns to zero, no TxReset pulse.
        applyStimulus(accepts);
        repeat (50) stepCycle();
        rst_i = 1'b1;
        #1;
        checkOutput("midreset busy", busy_o, 0);
        checkOutput("midreset txReset", txReset_o, 0);
        checkOutput("midreset frameCount", frameCount_o, 0);
        checkOutput("midreset inReady", inReady_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
